// File: rtl/bcd_down2.sv
// -----------------------------------------------------------------------------
// bcd_down2 - two-digit BCD countdown timer.
//
// Loads a two-digit BCD value (each digit clamped to 9), then decrements once
// per sampled x pulse while running. A decrement that lands on 00 pulses done
// for one cycle. With WRAP = 0 the count parks at 00 in EXPIRED. With WRAP = 1
// the count keeps running and the next x takes 00 to 99.
//
// Parameters:
//   WRAP      0 = stop at 00 and expire, 1 = wrap 00 -> 99 and keep running
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   x         decrement request, sampled each rising edge
//   load      parallel load strobe (wins over x)
//   load_val  [7:4] tens digit, [3:0] ones digit
//   bcd_ones  registered ones digit, 0-9
//   bcd_tens  registered tens digit, 0-9
//   busy      high while in RUN
//   zero      high when the count is 00
//   done      one-cycle pulse when a decrement produces 00
// -----------------------------------------------------------------------------
module bcd_down2 #(
    parameter bit WRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] bcd_ones,
    output logic [3:0] bcd_tens,
    output logic       busy,
    output logic       zero,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [3:0] ones_next, tens_next;
    logic       done_next;

    logic [3:0] load_ones, load_tens;
    logic       count_zero;

    // Each digit is clamped on its own so a bad nibble never becomes a non-BCD count.
    assign load_ones  = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];
    assign load_tens  = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];
    assign count_zero = (bcd_ones == 4'd0) && (bcd_tens == 4'd0);

    // NOTE: every variable gets its hold value first so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        ones_next  = bcd_ones;
        tens_next  = bcd_tens;
        done_next  = 1'b0;

        if (load) begin
            // Load beats x in every state; a simultaneous decrement is dropped.
            ones_next  = load_ones;
            tens_next  = load_tens;
            state_next = ((load_ones == 4'd0) && (load_tens == 4'd0)) ? IDLE : RUN;
        end else if ((state == RUN) && x) begin
            if (count_zero) begin
                // Only reachable with WRAP = 1: RUN at 00 rolls over to 99 silently.
                if (WRAP) begin
                    ones_next = 4'd9;
                    tens_next = 4'd9;
                end else begin
                    state_next = EXPIRED;
                end
            end else if (bcd_ones != 4'd0) begin
                ones_next = bcd_ones - 4'd1;
                if ((bcd_ones == 4'd1) && (bcd_tens == 4'd0)) begin
                    done_next  = 1'b1;
                    state_next = WRAP ? RUN : EXPIRED;
                end
            end else begin
                // Borrow: ones is 0 so tens must be nonzero here.
                ones_next = 4'd9;
                tens_next = bcd_tens - 4'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bcd_ones <= 4'd0;
            bcd_tens <= 4'd0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            bcd_ones <= ones_next;
            bcd_tens <= tens_next;
            done     <= done_next;
        end
    end

    // Decodes of registered state only; no input reaches an output combinationally.
    assign busy = (state == RUN);
    assign zero = count_zero;

endmodule

// File: tb/tb_bcd_down2.sv
// -----------------------------------------------------------------------------
// tb_bcd_down2 - self-checking bench for bcd_down2.
// Two instances (WRAP = 0 and WRAP = 1) share one stimulus stream. An integer
// countdown model predicts every output of both every cycle; directed steps add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_bcd_down2;

    logic       clk;
    logic       reset;
    logic       x;
    logic       load;
    logic [7:0] load_val;

    logic [3:0] ones0, tens0, ones1, tens1;
    logic       busy0, zero0, done0, busy1, zero1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_down2 #(.WRAP(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .x(x), .load(load), .load_val(load_val),
        .bcd_ones(ones0), .bcd_tens(tens0), .busy(busy0), .zero(zero0), .done(done0)
    );

    bcd_down2 #(.WRAP(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .x(x), .load(load), .load_val(load_val),
        .bcd_ones(ones1), .bcd_tens(tens1), .busy(busy1), .zero(zero1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Count held as a plain integer 0..99; index 0 = WRAP 0, index 1 = WRAP 1.
    int m_cnt [2];
    bit m_run [2];
    bit m_done[2];

    function automatic int clamp9(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_cnt[i]  = 0;
                m_run[i]  = 1'b0;
                m_done[i] = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                if (load) begin
                    m_cnt[i] = clamp9(int'(load_val[7:4])) * 10 + clamp9(int'(load_val[3:0]));
                    m_run[i] = (m_cnt[i] != 0);
                end else if (m_run[i] && x) begin
                    if (m_cnt[i] == 0) begin
                        m_cnt[i] = 99;
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                        if (m_cnt[i] == 0) begin
                            m_done[i] = 1'b1;
                            if (i == 0) m_run[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always begin
        @(posedge clk);
        #1;
        check("w0_tens", int'(tens0), m_cnt[0] / 10);
        check("w0_ones", int'(ones0), m_cnt[0] % 10);
        check("w0_busy", int'(busy0), int'(m_run[0]));
        check("w0_zero", int'(zero0), int'(m_cnt[0] == 0));
        check("w0_done", int'(done0), int'(m_done[0]));
        check("w1_tens", int'(tens1), m_cnt[1] / 10);
        check("w1_ones", int'(ones1), m_cnt[1] % 10);
        check("w1_busy", int'(busy1), int'(m_run[1]));
        check("w1_zero", int'(zero1), int'(m_cnt[1] == 0));
        check("w1_done", int'(done1), int'(m_done[1]));
    end

    // Drive inputs at the falling edge, then wait past the sampling edge.
    task automatic step(input logic xi, input logic li, input logic [7:0] v);
        @(negedge clk);
        x        = xi;
        load     = li;
        load_val = v;
        @(posedge clk);
        #2;
    endtask

    function automatic int cnt0();
        return int'(tens0) * 10 + int'(ones0);
    endfunction

    function automatic int cnt1();
        return int'(tens1) * 10 + int'(ones1);
    endfunction

    initial begin
        reset    = 1'b0;
        x        = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        #1;
        // Asynchronous reset state, before any clock edge.
        check("rst_count", cnt0(), 0);
        check("rst_zero",  int'(zero0), 1);
        check("rst_busy",  int'(busy0), 0);
        check("rst_done",  int'(done0), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // 1) x in IDLE is ignored.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'h00);
            check("idle_x_count", cnt0(), 0);
            check("idle_x_done", int'(done0), 0);
        end
        check("idle_busy", int'(busy0), 0);

        // 2) Load 12 and count down to 00.
        step(1'b0, 1'b1, 8'h12);
        check("load12_count", cnt0(), 12);
        check("load12_busy", int'(busy0), 1);
        check("load12_done", int'(done0), 0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 8'h00);
            check("down_count", cnt0(), 11 - i);
            check("down_done", int'(done0), (i == 11) ? 1 : 0);
        end
        check("expired_busy", int'(busy0), 0);
        check("wrap_at00_busy", int'(busy1), 1);
        step(1'b1, 1'b0, 8'h00);
        check("expired_hold", cnt0(), 0);
        check("expired_done", int'(done0), 0);
        check("wrap_99", cnt1(), 99);

        // 3) Borrow from tens.
        step(1'b0, 1'b1, 8'h10);
        step(1'b1, 1'b0, 8'h00);
        check("borrow_count", cnt0(), 9);
        check("borrow_busy", int'(busy0), 1);
        check("borrow_done", int'(done0), 0);

        // 4) WRAP = 1: 01 -> 00 (done) -> 99 -> 98.
        step(1'b0, 1'b1, 8'h01);
        step(1'b1, 1'b0, 8'h00);
        check("w1_to00", cnt1(), 0);
        check("w1_done00", int'(done1), 1);
        step(1'b1, 1'b0, 8'h00);
        check("w1_to99", cnt1(), 99);
        check("w1_done99", int'(done1), 0);
        step(1'b1, 1'b0, 8'h00);
        check("w1_to98", cnt1(), 98);
        check("w1_busy98", int'(busy1), 1);
        check("w0_exp_hold", cnt0(), 0);

        // 5) Clamping, load of 00, load beats x.
        step(1'b0, 1'b1, 8'hAF);
        check("clamp_AF", cnt0(), 99);
        step(1'b0, 1'b1, 8'hA3);
        check("clamp_A3", cnt0(), 93);
        step(1'b0, 1'b1, 8'h5F);
        check("clamp_5F", cnt0(), 59);
        step(1'b0, 1'b1, 8'h00);
        check("load00_zero", int'(zero0), 1);
        check("load00_busy", int'(busy0), 0);
        check("load00_done", int'(done0), 0);
        step(1'b1, 1'b1, 8'h05);
        check("load_x_count", cnt0(), 5);
        check("load_x_busy", int'(busy0), 1);
        step(1'b1, 1'b0, 8'h00);
        check("after_load_x", cnt0(), 4);
        // Load of 01 then 00 via decrement vs. load of 00: only the decrement pulses done.
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h00);
        check("load00_nodone", int'(done0), 0);

        // 6) Reset in the middle of a countdown.
        step(1'b0, 1'b1, 8'h30);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
        check("pre_reset_count", cnt0(), 26);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_count", cnt0(), 0);
        check("async_rst_busy", int'(busy0), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        check("post_rst_count", cnt0(), 0);
        check("post_rst_busy", int'(busy0), 0);
        check("post_rst_done", int'(done0), 0);
        check("post_rst_w1", cnt1(), 0);
        step(1'b0, 1'b0, 8'h00);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
